lowx_arbiter: RTL and testbench
===============================

Name: lowx_arbiter

Overview:
- Sits directly downstream of the instruction-cache and data-cache lowX ports.
- Merges both caches' line-refill, uncached and dirty-writeback requests onto one external memory port.
- Strictly one transaction outstanding at a time; requesters are served by round-robin grant.
- Returns each memory response to the requester that issued it, holding it until that requester accepts.

Parameters:
- XLEN, 32, address/word width.
- BLK_SIZE, 128, cache line width in bits; the refill and writeback data width.
- TIMEOUT, 1024, maximum cycles to wait for mem_rsp_valid_i before aborting a transaction.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- ic_req_valid_i  in  1  icache request (pulse or level).
- ic_req_addr_i  in  XLEN  icache request address.
- ic_req_uncached_i  in  1  icache uncached attribute.
- ic_req_ready_i  in  1  icache able to take a response.
- ic_res_ready_o  out  1  one-cycle request-accept pulse to icache.
- ic_res_valid_o  out  1  response valid to icache.
- ic_res_blk_o  out  BLK_SIZE  response line to icache.
- dc_req_valid_i  in  1  dcache request.
- dc_req_addr_i  in  XLEN  dcache request address.
- dc_req_uncached_i  in  1  dcache uncached attribute.
- dc_req_rw_i  in  1  1 = writeback/write.
- dc_req_rw_size_i  in  2  dcache access size.
- dc_req_data_i  in  BLK_SIZE  writeback data.
- dc_req_ready_i  in  1  dcache able to take a response.
- dc_res_ready_o  out  1  one-cycle request-accept pulse to dcache.
- dc_res_valid_o  out  1  response valid to dcache.
- dc_res_data_o  out  BLK_SIZE  response line to dcache.
- mem_req_valid_o  out  1  memory request valid.
- mem_req_ready_i  in  1  memory accepts request.
- mem_addr_o  out  XLEN  memory address.
- mem_we_o  out  1  write enable.
- mem_size_o  out  2  access size.
- mem_uncached_o  out  1  uncached attribute.
- mem_wdata_o  out  BLK_SIZE  write data.
- mem_rsp_valid_i  in  1  memory response valid.
- mem_rsp_data_i  in  BLK_SIZE  memory response data.
- timeout_o  out  1  sticky abort flag.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, rr_last = icache, timer = 0, timeout_o = 0. A reset mid-transaction drops the latched request and any pending response, with no memory retry.
- FSM states are IDLE, ISSUE, WAIT, RESP.
- IDLE: if either request valid, grant one of them.
  - Only one valid: grant it.
  - Both valid: grant the port opposite to rr_last.
  - On grant: latch addr/uncached/rw/size/data (icache rw = 0, size = 2'b11, data = 0), pulse the granted *_res_ready_o for exactly this cycle, update rr_last, go to ISSUE.
  - A request arriving during a non-IDLE state is not accepted; the cache keeps it pending.
- ISSUE: mem_req_valid_o = 1 with latched fields, held stable until mem_req_ready_i. On accept go to WAIT and clear the timer.
- WAIT: the timer increments each cycle.
  - On mem_rsp_valid_i: capture mem_rsp_data_i (write transactions still need the response) and go to RESP.
  - If the timer reaches TIMEOUT-1 with no response: set timeout_o, capture data = 0, go to RESP.
  - mem_rsp_valid_i outside WAIT is ignored.
- RESP: the owner's *_res_valid_o = 1 and its data output carries the captured line, both held until the owner's *_req_ready_i. On the handshake go to IDLE; the next grant happens at the earliest on the following cycle.
- Fixed latencies and limits:
  - Minimum latency, grant to response valid, is 3 cycles: grant at T, mem accept at T+1, response at T+2, res_valid at T+3.
  - The non-owner port never sees res_valid or res_ready.
  - Response data outputs are 0 whenever the matching valid is 0.
- timeout_o is cleared only by reset.

Test Plan:
- Single icache refill, addr 0x0000_1040, mem ready immediately, data 0xA5..A5 at T+2 -> ic_res_ready_o pulses at T, ic_res_valid_o = 1 at T+3 with the line, dc_* outputs stay 0.
- icache and dcache request in the same cycle after reset -> dcache granted first (rr_last = icache), icache granted on the cycle after dcache's response handshake; the next simultaneous pair grants icache.
- dcache writeback, rw = 1, addr 0x8000_0200, data pattern -> mem_we_o = 1, mem_size_o = 2'b11, mem_wdata_o equals the pattern; dc_res_valid_o is asserted after mem_rsp_valid_i.
- mem_req_ready_i low for 5 cycles -> mem_req_valid_o and all fields held stable for those 5 cycles, no grant pulse to a newly arriving request.
- Response back-pressure, dc_req_ready_i low for 4 cycles in RESP -> dc_res_valid_o and its data held for 4 cycles, with no new grant.
- No memory response for TIMEOUT cycles -> timeout_o = 1, owner receives res_valid with data 0, FSM returns to IDLE. Then assert rst_i in WAIT -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/lowx_arbiter.sv
// Merges icache and dcache lowX requests onto a single memory port: one transaction
// outstanding, round-robin grant, and each response routed back to the requester that issued it.
module lowx_arbiter #(
    parameter int XLEN     = 32,
    parameter int BLK_SIZE = 128,
    parameter int TIMEOUT  = 1024
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                ic_req_valid_i,
    input  logic [XLEN-1:0]     ic_req_addr_i,
    input  logic                ic_req_uncached_i,
    input  logic                ic_req_ready_i,
    output logic                ic_res_ready_o,
    output logic                ic_res_valid_o,
    output logic [BLK_SIZE-1:0] ic_res_blk_o,
    input  logic                dc_req_valid_i,
    input  logic [XLEN-1:0]     dc_req_addr_i,
    input  logic                dc_req_uncached_i,
    input  logic                dc_req_rw_i,
    input  logic [1:0]          dc_req_rw_size_i,
    input  logic [BLK_SIZE-1:0] dc_req_data_i,
    input  logic                dc_req_ready_i,
    output logic                dc_res_ready_o,
    output logic                dc_res_valid_o,
    output logic [BLK_SIZE-1:0] dc_res_data_o,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [XLEN-1:0]     mem_addr_o,
    output logic                mem_we_o,
    output logic [1:0]          mem_size_o,
    output logic                mem_uncached_o,
    output logic [BLK_SIZE-1:0] mem_wdata_o,
    input  logic                mem_rsp_valid_i,
    input  logic [BLK_SIZE-1:0] mem_rsp_data_i,
    output logic                timeout_o
);
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic                rr_last_dc_q;
    logic                owner_dc_q;
    logic [TW-1:0]       timer_q;
    logic                timeout_q;
    logic                grant_ic, grant_dc, owner_ready;
    logic [XLEN-1:0]     addr_q;
    logic                uncached_q, we_q;
    logic [1:0]          size_q;
    logic [BLK_SIZE-1:0] wdata_q, line_q;

    always_comb begin
        state_d     = state_q;
        grant_ic    = 1'b0;
        grant_dc    = 1'b0;
        owner_ready = owner_dc_q ? dc_req_ready_i : ic_req_ready_i;
        case (state_q)
            IDLE: begin
                if (ic_req_valid_i && dc_req_valid_i) begin
                    grant_dc = !rr_last_dc_q;
                    grant_ic = rr_last_dc_q;
                end else begin
                    grant_ic = ic_req_valid_i;
                    grant_dc = dc_req_valid_i;
                end
                if (grant_ic || grant_dc) state_d = ISSUE;
            end
            ISSUE:   if (mem_req_ready_i) state_d = WAIT;
            WAIT:    if (mem_rsp_valid_i || timer_q == TIMER_MAX) state_d = RESP;
            RESP:    if (owner_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            rr_last_dc_q <= 1'b0;
            owner_dc_q   <= 1'b0;
            timer_q      <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant_ic || grant_dc) begin
                owner_dc_q   <= grant_dc;
                rr_last_dc_q <= grant_dc;
            end
            if (state_q == ISSUE) timer_q <= '0;
            else if (state_q == WAIT) timer_q <= timer_q + 1'b1;
            if (state_q == WAIT && !mem_rsp_valid_i && timer_q == TIMER_MAX) timeout_q <= 1'b1;
        end
    end

    // Request/response payload needs no reset: every output path is gated by FSM state.
    always_ff @(posedge clk_i) begin
        if (grant_dc) begin
            addr_q     <= dc_req_addr_i;
            uncached_q <= dc_req_uncached_i;
            we_q       <= dc_req_rw_i;
            size_q     <= dc_req_rw_size_i;
            wdata_q    <= dc_req_data_i;
        end else if (grant_ic) begin
            addr_q     <= ic_req_addr_i;
            uncached_q <= ic_req_uncached_i;
            we_q       <= 1'b0;
            size_q     <= 2'b11;
            wdata_q    <= '0;
        end
        if (state_q == WAIT) begin
            if (mem_rsp_valid_i) line_q <= mem_rsp_data_i;
            else if (timer_q == TIMER_MAX) line_q <= '0;
        end
    end

    assign ic_res_ready_o  = grant_ic;
    assign dc_res_ready_o  = grant_dc;
    assign mem_req_valid_o = (state_q == ISSUE);
    assign mem_addr_o      = mem_req_valid_o ? addr_q : '0;
    assign mem_we_o        = mem_req_valid_o & we_q;
    assign mem_size_o      = mem_req_valid_o ? size_q : 2'b00;
    assign mem_uncached_o  = mem_req_valid_o & uncached_q;
    assign mem_wdata_o     = mem_req_valid_o ? wdata_q : '0;
    assign ic_res_valid_o  = (state_q == RESP) && !owner_dc_q;
    assign dc_res_valid_o  = (state_q == RESP) && owner_dc_q;
    assign ic_res_blk_o    = ic_res_valid_o ? line_q : '0;
    assign dc_res_data_o   = dc_res_valid_o ? line_q : '0;
    assign timeout_o       = timeout_q;
endmodule

// File: tb/tb_lowx_arbiter.sv
// Bench for lowx_arbiter: directed vector table, hand-written arbitration/timeout/reset
// sequences, then random traffic checked against a transaction-level model.
module tb_lowx_arbiter;
    localparam int TO = 20;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         ic_req_valid_i = 0, ic_req_uncached_i = 0, ic_req_ready_i = 0;
    logic [31:0]  ic_req_addr_i = 0;
    logic         ic_res_ready_o, ic_res_valid_o;
    logic [127:0] ic_res_blk_o;
    logic         dc_req_valid_i = 0, dc_req_uncached_i = 0, dc_req_rw_i = 0, dc_req_ready_i = 0;
    logic [31:0]  dc_req_addr_i = 0;
    logic [1:0]   dc_req_rw_size_i = 0;
    logic [127:0] dc_req_data_i = 0;
    logic         dc_res_ready_o, dc_res_valid_o;
    logic [127:0] dc_res_data_o;
    logic         mem_req_valid_o, mem_req_ready_i = 0, mem_we_o, mem_uncached_o;
    logic [31:0]  mem_addr_o;
    logic [1:0]   mem_size_o;
    logic [127:0] mem_wdata_o;
    logic         mem_rsp_valid_i = 0;
    logic [127:0] mem_rsp_data_i = 0;
    logic         timeout_o;

    int total = 0;
    int bad   = 0;

    lowx_arbiter #(.XLEN(32), .BLK_SIZE(128), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ic_req_valid_i(ic_req_valid_i), .ic_req_addr_i(ic_req_addr_i),
        .ic_req_uncached_i(ic_req_uncached_i), .ic_req_ready_i(ic_req_ready_i),
        .ic_res_ready_o(ic_res_ready_o), .ic_res_valid_o(ic_res_valid_o), .ic_res_blk_o(ic_res_blk_o),
        .dc_req_valid_i(dc_req_valid_i), .dc_req_addr_i(dc_req_addr_i),
        .dc_req_uncached_i(dc_req_uncached_i), .dc_req_rw_i(dc_req_rw_i),
        .dc_req_rw_size_i(dc_req_rw_size_i), .dc_req_data_i(dc_req_data_i),
        .dc_req_ready_i(dc_req_ready_i), .dc_res_ready_o(dc_res_ready_o),
        .dc_res_valid_o(dc_res_valid_o), .dc_res_data_o(dc_res_data_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_size_o(mem_size_o),
        .mem_uncached_o(mem_uncached_o), .mem_wdata_o(mem_wdata_o),
        .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_data_i(mem_rsp_data_i),
        .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, limit reached", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {ic_res_ready_o, ic_res_valid_o, dc_res_ready_o, dc_res_valid_o,
                            mem_req_valid_o, mem_we_o, mem_size_o, mem_uncached_o, timeout_o}, 0);
        chk({tag, "_data"}, ic_res_blk_o | dc_res_data_o | mem_wdata_o | {96'b0, mem_addr_o}, 0);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        ic_req_valid_i = 0; dc_req_valid_i = 0; ic_req_ready_i = 0; dc_req_ready_i = 0;
        mem_req_ready_i = 0; mem_rsp_valid_i = 0; rst_i = 1;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 0;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    typedef struct {
        logic         is_dc;
        logic [31:0]  addr;
        logic         unc;
        logic         rw;
        logic [1:0]   size;
        logic [127:0] wdata;
        logic [127:0] rdata;
        int           mem_stall;
        int           rsp_dly;
        int           bp;
        logic         exp_we;
        logic [1:0]   exp_size;
        logic [127:0] exp_wdata;
    } vec_t;

    vec_t vecs[5];

    // One full transaction; the other cache raises a request throughout and must not be granted.
    task automatic run_vec(input vec_t v);
        @(negedge clk_i);
        if (v.is_dc) begin
            dc_req_valid_i = 1; dc_req_addr_i = v.addr; dc_req_uncached_i = v.unc;
            dc_req_rw_i = v.rw; dc_req_rw_size_i = v.size; dc_req_data_i = v.wdata;
        end else begin
            ic_req_valid_i = 1; ic_req_addr_i = v.addr; ic_req_uncached_i = v.unc;
        end
        #1;
        chk("grant_own", v.is_dc ? dc_res_ready_o : ic_res_ready_o, 1);
        chk("grant_other", v.is_dc ? ic_res_ready_o : dc_res_ready_o, 0);
        chk("memv_at_grant", mem_req_valid_o, 0);
        for (int k = 0; k <= v.mem_stall; k++) begin
            @(negedge clk_i);
            ic_req_valid_i = v.is_dc;
            dc_req_valid_i = !v.is_dc;
            mem_req_ready_i = (k == v.mem_stall);
            #1;
            chk("issue_fields", {mem_req_valid_o, mem_we_o, mem_size_o, mem_uncached_o, mem_addr_o},
                {1'b1, v.exp_we, v.exp_size, v.unc, v.addr});
            chk("issue_wdata", mem_wdata_o, v.exp_wdata);
            chk("no_grant_issue", {ic_res_ready_o, dc_res_ready_o}, 0);
        end
        for (int d = 0; d <= v.rsp_dly; d++) begin
            @(negedge clk_i);
            mem_req_ready_i = 0;
            mem_rsp_valid_i = (d == v.rsp_dly);
            mem_rsp_data_i  = (d == v.rsp_dly) ? v.rdata : ~v.rdata;
            #1;
            chk("wait_quiet", {mem_req_valid_o, ic_res_valid_o, dc_res_valid_o,
                               ic_res_ready_o, dc_res_ready_o}, 0);
        end
        for (int b = 0; b <= v.bp; b++) begin
            @(negedge clk_i);
            mem_rsp_valid_i = 0;
            mem_rsp_data_i = ~v.rdata;
            if (v.is_dc) dc_req_ready_i = (b == v.bp);
            else ic_req_ready_i = (b == v.bp);
            if (b == v.bp) begin
                ic_req_valid_i = 0;
                dc_req_valid_i = 0;
            end
            #1;
            chk("resp_valid", {ic_res_valid_o, dc_res_valid_o}, v.is_dc ? 2'b01 : 2'b10);
            chk("resp_data", v.is_dc ? dc_res_data_o : ic_res_blk_o, v.rdata);
            chk("resp_other_data", v.is_dc ? ic_res_blk_o : dc_res_data_o, 0);
            chk("no_grant_resp", {ic_res_ready_o, dc_res_ready_o}, 0);
        end
        @(negedge clk_i);
        ic_req_ready_i = 0; dc_req_ready_i = 0;
        #1;
        chk("back_idle", {ic_res_valid_o, dc_res_valid_o, ic_res_ready_o, dc_res_ready_o, mem_req_valid_o}, 0);
        chk("idle_data", ic_res_blk_o | dc_res_data_o, 0);
    endtask

    // Complete an already-granted transaction with no stalls; optionally re-raise the owner's
    // request (with a new address) in the response handshake cycle.
    task automatic serve(input logic is_dc, input logic [31:0] exp_addr, input logic [127:0] rdata,
                         input logic re_req, input logic [31:0] new_addr, input string tag);
        @(negedge clk_i);
        if (is_dc) dc_req_valid_i = 0; else ic_req_valid_i = 0;
        mem_req_ready_i = 1;
        #1;
        chk({tag, "_addr"}, {mem_req_valid_o, mem_we_o, mem_addr_o}, {1'b1, 1'b0, exp_addr});
        @(negedge clk_i);
        mem_req_ready_i = 0; mem_rsp_valid_i = 1; mem_rsp_data_i = rdata;
        @(negedge clk_i);
        mem_rsp_valid_i = 0;
        if (is_dc) dc_req_ready_i = 1; else ic_req_ready_i = 1;
        if (re_req) begin
            if (is_dc) begin dc_req_valid_i = 1; dc_req_addr_i = new_addr; end
            else begin ic_req_valid_i = 1; ic_req_addr_i = new_addr; end
        end
        #1;
        chk({tag, "_data"}, is_dc ? dc_res_data_o : ic_res_blk_o, rdata);
        chk({tag, "_hold"}, {ic_res_ready_o, dc_res_ready_o}, 0);
        @(negedge clk_i);
        ic_req_ready_i = 0; dc_req_ready_i = 0;
    endtask

    // Random-traffic model state
    int           ic_st, dc_st;          // 0 idle, 1 request pending, 2 awaiting response
    logic         busy, issuing, mem_out, resp_pend, owner_dc, last_dc;
    int           mem_cnt;
    logic [127:0] line;
    logic [31:0]  e_addr;
    logic         e_we, e_unc;
    logic [1:0]   e_size;
    logic [127:0] e_wd;
    logic [1:0]   exp_g;
    int           quiet;

    initial begin
        vecs[0] = '{1'b0, 32'h0000_1040, 1'b0, 1'b0, 2'b00, 128'h0, {16{8'hA5}}, 0, 0, 0,
                    1'b0, 2'b11, 128'h0};
        vecs[1] = '{1'b1, 32'h8000_0200, 1'b0, 1'b1, 2'b11, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                    128'h1111_2222_3333_4444_5555_6666_7777_8888, 0, 1, 0,
                    1'b1, 2'b11, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210};
        vecs[2] = '{1'b0, 32'h0000_2000, 1'b1, 1'b0, 2'b00, 128'h0, 128'hDEAD_BEEF_0BAD_F00D_CAFE_BABE_1234_5678,
                    5, 2, 0, 1'b0, 2'b11, 128'h0};
        vecs[3] = '{1'b1, 32'h4000_0004, 1'b1, 1'b0, 2'b10, 128'h5A5A_0000_FFFF_1234_0000_0000_9999_0001,
                    {8{16'h55AA}}, 1, 0, 4, 1'b0, 2'b10, 128'h5A5A_0000_FFFF_1234_0000_0000_9999_0001};
        vecs[4] = '{1'b1, 32'h0000_0FFC, 1'b0, 1'b1, 2'b01, {4{32'hC0DE_0001}}, {4{32'h0F0F_F0F0}},
                    2, 3, 2, 1'b1, 2'b01, {4{32'hC0DE_0001}}};

        do_reset();
        #1;
        chk_all_zero("reset");

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Round-robin: simultaneous pair after reset goes to dcache first.
        do_reset();
        ic_req_valid_i = 1; ic_req_addr_i = 32'h0000_0100; ic_req_uncached_i = 0;
        dc_req_valid_i = 1; dc_req_addr_i = 32'h0000_0200; dc_req_rw_i = 0;
        dc_req_uncached_i = 0; dc_req_rw_size_i = 2'b11;
        #1;
        chk("rr_first", {ic_res_ready_o, dc_res_ready_o}, 2'b01);
        serve(1'b1, 32'h0000_0200, 128'hD1, 1'b1, 32'h0000_0300, "rr_dc1");
        #1;
        chk("rr_second", {ic_res_ready_o, dc_res_ready_o}, 2'b10);
        serve(1'b0, 32'h0000_0100, 128'hE2, 1'b0, 32'h0, "rr_ic");
        #1;
        chk("rr_third", {ic_res_ready_o, dc_res_ready_o}, 2'b01);
        serve(1'b1, 32'h0000_0300, 128'hF3, 1'b0, 32'h0, "rr_dc2");
        #1;
        chk("rr_idle", {ic_res_ready_o, dc_res_ready_o, ic_res_valid_o, dc_res_valid_o}, 0);

        // Timeout: memory accepts but never answers.
        @(negedge clk_i);
        ic_req_valid_i = 1; ic_req_addr_i = 32'h0000_3000;
        #1;
        chk("to_grant", ic_res_ready_o, 1);
        @(negedge clk_i);
        ic_req_valid_i = 0; mem_req_ready_i = 1; mem_rsp_data_i = {4{32'hBAD0_BAD0}};
        quiet = 1;
        for (int w = 1; w <= TO; w++) begin
            @(negedge clk_i);
            mem_req_ready_i = 0;
            #1;
            if (ic_res_valid_o || timeout_o) quiet = 0;
        end
        chk("to_quiet", quiet, 1);
        @(negedge clk_i);
        ic_req_ready_i = 1;
        #1;
        chk("to_valid", {ic_res_valid_o, dc_res_valid_o, timeout_o}, 3'b101);
        chk("to_data", ic_res_blk_o, 0);
        @(negedge clk_i);
        ic_req_ready_i = 0;
        #1;
        chk("to_sticky", {timeout_o, ic_res_valid_o}, 2'b10);

        // Reset while waiting on memory drops the transaction.
        @(negedge clk_i);
        dc_req_valid_i = 1; dc_req_addr_i = 32'h0000_4000;
        @(negedge clk_i);
        dc_req_valid_i = 0; mem_req_ready_i = 1;
        @(negedge clk_i);
        mem_req_ready_i = 0; rst_i = 1;
        @(negedge clk_i);
        rst_i = 0;
        #1;
        chk_all_zero("rst_wait");
        @(negedge clk_i);
        mem_rsp_valid_i = 1; mem_rsp_data_i = 128'h77;
        #1;
        @(negedge clk_i);
        mem_rsp_valid_i = 0;
        #1;
        chk_all_zero("rst_after");

        // Random traffic against the transaction-level model.
        do_reset();
        ic_st = 0; dc_st = 0; busy = 0; issuing = 0; mem_out = 0; resp_pend = 0;
        owner_dc = 0; last_dc = 0; mem_cnt = 0; line = 0;
        e_addr = 0; e_we = 0; e_unc = 0; e_size = 0; e_wd = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c > 0) @(negedge clk_i);
            ic_req_valid_i  = (ic_st == 1);
            dc_req_valid_i  = (dc_st == 1);
            ic_req_ready_i  = ($urandom_range(0, 3) != 0);
            dc_req_ready_i  = ($urandom_range(0, 3) != 0);
            mem_req_ready_i = ($urandom_range(0, 2) == 0);
            if (mem_out && mem_cnt == 0) begin
                mem_rsp_valid_i = 1; mem_rsp_data_i = rand128();
            end else if (!mem_out) begin
                mem_rsp_valid_i = ($urandom_range(0, 7) == 0); mem_rsp_data_i = rand128();
            end else begin
                mem_rsp_valid_i = 0;
            end
            #1;
            exp_g = 2'b00;
            if (!busy && (ic_st == 1 || dc_st == 1)) begin
                if (ic_st == 1 && dc_st == 1) exp_g = last_dc ? 2'b10 : 2'b01;
                else exp_g = (ic_st == 1) ? 2'b10 : 2'b01;
            end
            chk("rnd_grant", {ic_res_ready_o, dc_res_ready_o}, exp_g);
            chk("rnd_memv", mem_req_valid_o, issuing);
            if (issuing) begin
                chk("rnd_mem_fields", {mem_we_o, mem_size_o, mem_uncached_o, mem_addr_o},
                    {e_we, e_size, e_unc, e_addr});
                chk("rnd_mem_wdata", mem_wdata_o, e_wd);
            end
            chk("rnd_resv", {ic_res_valid_o, dc_res_valid_o},
                resp_pend ? (owner_dc ? 2'b01 : 2'b10) : 2'b00);
            chk("rnd_ic_data", ic_res_blk_o, (resp_pend && !owner_dc) ? line : 128'h0);
            chk("rnd_dc_data", dc_res_data_o, (resp_pend && owner_dc) ? line : 128'h0);

            if (resp_pend && (owner_dc ? dc_req_ready_i : ic_req_ready_i)) begin
                resp_pend = 0; busy = 0;
                if (owner_dc) dc_st = 0; else ic_st = 0;
            end
            if (mem_out && mem_cnt == 0) begin
                line = mem_rsp_data_i; mem_out = 0; resp_pend = 1;
            end else if (mem_out) begin
                mem_cnt--;
            end
            if (issuing && mem_req_ready_i) begin
                issuing = 0; mem_out = 1; mem_cnt = $urandom_range(0, 8);
            end
            if (exp_g != 2'b00) begin
                busy = 1; issuing = 1; owner_dc = exp_g[0]; last_dc = exp_g[0];
                if (owner_dc) begin
                    e_addr = dc_req_addr_i; e_we = dc_req_rw_i; e_size = dc_req_rw_size_i;
                    e_unc = dc_req_uncached_i; e_wd = dc_req_data_i; dc_st = 2;
                end else begin
                    e_addr = ic_req_addr_i; e_we = 0; e_size = 2'b11;
                    e_unc = ic_req_uncached_i; e_wd = 0; ic_st = 2;
                end
            end
            if (ic_st == 0 && $urandom_range(0, 3) == 0) begin
                ic_st = 1; ic_req_addr_i = $urandom; ic_req_uncached_i = $urandom_range(0, 1);
            end
            if (dc_st == 0 && $urandom_range(0, 3) == 0) begin
                dc_st = 1; dc_req_addr_i = $urandom; dc_req_uncached_i = $urandom_range(0, 1);
                dc_req_rw_i = $urandom_range(0, 1); dc_req_rw_size_i = 2'($urandom_range(0, 3));
                dc_req_data_i = rand128();
            end
        end
        chk("rnd_no_timeout", timeout_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
